known_ch_table: RTL and testbench

- Parametrised successor to the single-entry known-cluster-head register.
- Stores up to DEPTH cluster-head (CH) advertisements, each as ID, hop count and Q-value, received during the heartbeat/CHE phase.
- Sequentially selects the best CH for the node's uplink and presents it on chosenCH and hopsFromCH.
- Adds features the single-entry block lacks: entry update, own-ID filtering, replace-worst on full, busy/drop handshake.

---
 rtl/known_ch_if.sv | 28 ++
 rtl/known_ch_table.sv | 109 ++++++++++
 tb/tb_known_ch_table.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/known_ch_if.sv
// known_ch_if: advert inputs and selected-CH outputs of the known-CH table
interface known_ch_if #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic en_KCH;
  logic HB_reset;
  logic [WORD_WIDTH-1:0] node_ID;
  logic [WORD_WIDTH-1:0] fCH_ID;
  logic [WORD_WIDTH-1:0] fCH_Hops;
  logic [WORD_WIDTH-1:0] fCH_QValue;
  logic [WORD_WIDTH-1:0] chosenCH;
  logic [WORD_WIDTH-1:0] hopsFromCH;
  logic [WORD_WIDTH-1:0] chosenQ;
  logic kch_valid;
  logic kch_busy;
  logic [CNT_W-1:0] kch_count;
  logic kch_drop;
  modport master (
    output en_KCH, HB_reset, node_ID, fCH_ID, fCH_Hops, fCH_QValue,
    input chosenCH, hopsFromCH, chosenQ, kch_valid, kch_busy, kch_count, kch_drop
  );
  modport slave (
    input en_KCH, HB_reset, node_ID, fCH_ID, fCH_Hops, fCH_QValue,
    output chosenCH, hopsFromCH, chosenQ, kch_valid, kch_busy, kch_count, kch_drop
  );
endinterface

// File: rtl/known_ch_table.sv
// known_ch_table: DEPTH-entry cluster-head advert table with sequential best-CH selection
module known_ch_table #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic nrst,
  known_ch_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SCAN, WRITE, SELECT} state_t;
  state_t state;
  logic [DEPTH-1:0] vld;
  logic [WORD_WIDTH-1:0] ids [DEPTH];
  logic [WORD_WIDTH-1:0] hops [DEPTH];
  logic [WORD_WIDTH-1:0] qs [DEPTH];
  logic [WORD_WIDTH-1:0] lId, lHops, lQ;
  logic [IW-1:0] idx, matchIdx, freeIdx, worstIdx, bestIdx, selIdx;
  logic matchHit, freeHit, worstHit, bestHit;
  logic last, curWorse, curBest, advBetter;

  // Q higher first, then fewer hops, then lower ID
  function automatic logic better(input logic [WORD_WIDTH-1:0] qa, ha, ia, qb, hb, ib);
    return qa > qb || (qa == qb && (ha < hb || (ha == hb && ia < ib)));
  endfunction

  always_comb begin
    last = idx == IW'(DEPTH - 1);
    curWorse = vld[idx] && (!worstHit || better(qs[worstIdx], hops[worstIdx], ids[worstIdx], qs[idx], hops[idx], ids[idx]));
    curBest = vld[idx] && (!bestHit || better(qs[idx], hops[idx], ids[idx], qs[bestIdx], hops[bestIdx], ids[bestIdx]));
    selIdx = curBest ? idx : bestIdx;
    advBetter = better(lQ, lHops, lId, qs[worstIdx], hops[worstIdx], ids[worstIdx]);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      vld <= '0;
      idx <= '0;
      {matchIdx, freeIdx, worstIdx, bestIdx} <= '0;
      {matchHit, freeHit, worstHit, bestHit} <= '0;
      {lId, lHops, lQ} <= '0;
      bus.chosenCH <= '0;
      bus.hopsFromCH <= '1;
      bus.chosenQ <= '0;
      bus.kch_valid <= 1'b0;
      bus.kch_busy <= 1'b0;
      bus.kch_count <= '0;
      bus.kch_drop <= 1'b0;
    end else if (bus.HB_reset) begin
      state <= IDLE;
      vld <= '0;
      bus.chosenCH <= '0;
      bus.hopsFromCH <= '1;
      bus.chosenQ <= '0;
      bus.kch_valid <= 1'b0;
      bus.kch_busy <= 1'b0;
      bus.kch_count <= '0;
      bus.kch_drop <= 1'b0;
    end else begin
      bus.kch_drop <= bus.en_KCH && state != IDLE;
      case (state)
        IDLE: if (bus.en_KCH && bus.fCH_ID != bus.node_ID) begin
          {lId, lHops, lQ} <= {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue};
          {matchHit, freeHit, worstHit} <= '0;
          idx <= '0;
          bus.kch_busy <= 1'b1;
          state <= SCAN;
        end
        SCAN: begin
          if (vld[idx] && ids[idx] == lId) {matchHit, matchIdx} <= {1'b1, idx};
          if (!vld[idx] && !freeHit) {freeHit, freeIdx} <= {1'b1, idx};
          if (curWorse) {worstHit, worstIdx} <= {1'b1, idx};
          idx <= idx + 1'b1;
          if (last) state <= WRITE;
        end
        WRITE: begin
          if (matchHit) begin
            hops[matchIdx] <= lHops;
            qs[matchIdx] <= lQ;
          end else if (freeHit) begin
            vld[freeIdx] <= 1'b1;
            {ids[freeIdx], hops[freeIdx], qs[freeIdx]} <= {lId, lHops, lQ};
            bus.kch_count <= bus.kch_count + CNT_W'(1);
          end else if (advBetter) begin
            {ids[worstIdx], hops[worstIdx], qs[worstIdx]} <= {lId, lHops, lQ};
          end else bus.kch_drop <= 1'b1;
          idx <= '0;
          bestHit <= 1'b0;
          state <= SELECT;
        end
        default: begin
          bestHit <= bestHit | vld[idx];
          bestIdx <= selIdx;
          idx <= idx + 1'b1;
          if (last) begin
            bus.chosenCH <= (bestHit | vld[idx]) ? ids[selIdx] : '0;
            bus.hopsFromCH <= (bestHit | vld[idx]) ? hops[selIdx] : '1;
            bus.chosenQ <= (bestHit | vld[idx]) ? qs[selIdx] : '0;
            bus.kch_valid <= bus.kch_count != '0;
            bus.kch_busy <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_known_ch_table.sv
// tb_known_ch_table: directed checks of fill, ranking, update, full-table, busy and reset behaviour
module tb_known_ch_table;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int failures = 0;
  int busyCyc, drops;
  always #5 clk = ~clk;

  known_ch_if #(.WORD_WIDTH(16), .DEPTH(4)) bus ();
  known_ch_table #(.WORD_WIDTH(16), .DEPTH(4)) dut (.clk(clk), .nrst(nrst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic [15:0] ch, h, q, input logic v, input logic [2:0] cnt);
    chk({tag, ".ch"}, bus.chosenCH, ch);
    chk({tag, ".hops"}, bus.hopsFromCH, h);
    chk({tag, ".q"}, bus.chosenQ, q);
    chk({tag, ".valid"}, bus.kch_valid, v);
    chk({tag, ".count"}, bus.kch_count, cnt);
  endtask

  task automatic advert(input logic [15:0] id, h, q, output int bc, output int dr);
    @(negedge clk);
    bus.en_KCH = 1'b1;
    {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue} = {id, h, q};
    @(negedge clk);
    bus.en_KCH = 1'b0;
    bc = 0;
    dr = 0;
    while (bus.kch_busy && bc < 50) begin
      bc++;
      dr += int'(bus.kch_drop);
      @(negedge clk);
    end
    dr += int'(bus.kch_drop);
  endtask

  task automatic hbPulse();
    @(negedge clk);
    bus.HB_reset = 1'b1;
    @(negedge clk);
    bus.HB_reset = 1'b0;
  endtask

  initial begin
    int n;
    bus.en_KCH = 1'b0;
    bus.HB_reset = 1'b0;
    bus.node_ID = 16'd12;
    {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue} = '0;
    #12;
    chkOut("rst", 16'h0, 16'hFFFF, 16'h0, 1'b0, 3'd0);
    chk("rst.busy", bus.kch_busy, 0);
    chk("rst.drop", bus.kch_drop, 0);
    @(negedge clk);
    nrst = 1'b1;
    hbPulse();
    // basic fill and ranking
    advert(16'd23, 16'd2, 16'h3000, busyCyc, drops);
    chk("fill.busyCycles", busyCyc, 9);
    chk("fill.drops", drops, 0);
    chkOut("fill", 16'd23, 16'd2, 16'h3000, 1'b1, 3'd1);
    advert(16'd45, 16'd2, 16'h2000, busyCyc, drops);
    chk("rank1.busyCycles", busyCyc, 9);
    chkOut("rank1", 16'd23, 16'd2, 16'h3000, 1'b1, 3'd2);
    advert(16'd6, 16'd1, 16'h4000, busyCyc, drops);
    chkOut("rank2", 16'd6, 16'd1, 16'h4000, 1'b1, 3'd3);
    // own ID and update
    advert(16'd12, 16'd1, 16'h4000, busyCyc, drops);
    chk("ownId.busyCycles", busyCyc, 0);
    chk("ownId.drops", drops, 0);
    chkOut("ownId", 16'd6, 16'd1, 16'h4000, 1'b1, 3'd3);
    advert(16'd6, 16'd1, 16'h1000, busyCyc, drops);
    chkOut("update", 16'd23, 16'd2, 16'h3000, 1'b1, 3'd3);
    // tie-breaks (second and third adverts replace the worst entry of a full table)
    advert(16'd30, 16'd1, 16'h4000, busyCyc, drops);
    chkOut("tie1", 16'd30, 16'd1, 16'h4000, 1'b1, 3'd4);
    advert(16'd7, 16'd1, 16'h4000, busyCyc, drops);
    chk("tie2.drops", drops, 0);
    chkOut("tie2", 16'd7, 16'd1, 16'h4000, 1'b1, 3'd4);
    advert(16'd5, 16'd2, 16'h4000, busyCyc, drops);
    chkOut("tie3", 16'd7, 16'd1, 16'h4000, 1'b1, 3'd4);
    // full table 0x1000..0x4000
    hbPulse();
    chkOut("hb", 16'h0, 16'hFFFF, 16'h0, 1'b0, 3'd0);
    advert(16'd1, 16'd1, 16'h1000, busyCyc, drops);
    advert(16'd2, 16'd1, 16'h2000, busyCyc, drops);
    advert(16'd3, 16'd1, 16'h3000, busyCyc, drops);
    advert(16'd4, 16'd1, 16'h4000, busyCyc, drops);
    chkOut("full", 16'd4, 16'd1, 16'h4000, 1'b1, 3'd4);
    advert(16'd9, 16'd1, 16'h0800, busyCyc, drops);
    chk("fullLow.busyCycles", busyCyc, 9);
    chk("fullLow.drops", drops, 1);
    chkOut("fullLow", 16'd4, 16'd1, 16'h4000, 1'b1, 3'd4);
    advert(16'd9, 16'd1, 16'h5000, busyCyc, drops);
    chk("fullHigh.drops", drops, 0);
    chkOut("fullHigh", 16'd9, 16'd1, 16'h5000, 1'b1, 3'd4);
    advert(16'd8, 16'd1, 16'h1800, busyCyc, drops);
    chk("worstGone.drops", drops, 1);
    // en_KCH while busy
    @(negedge clk);
    bus.en_KCH = 1'b1;
    {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue} = {16'd10, 16'd1, 16'h6000};
    @(negedge clk);
    bus.en_KCH = 1'b0;
    @(negedge clk);
    bus.en_KCH = 1'b1;
    {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue} = {16'd11, 16'd1, 16'h7000};
    @(negedge clk);
    bus.en_KCH = 1'b0;
    chk("coll.drop", bus.kch_drop, 1);
    chk("coll.busy", bus.kch_busy, 1);
    @(negedge clk);
    chk("coll.dropOnce", bus.kch_drop, 0);
    n = 0;
    while (bus.kch_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("coll.done", bus.kch_busy, 0);
    chkOut("coll", 16'd10, 16'd1, 16'h6000, 1'b1, 3'd4);
    // HB_reset mid-SCAN with a colliding en_KCH
    @(negedge clk);
    bus.en_KCH = 1'b1;
    {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue} = {16'd20, 16'd1, 16'h0100};
    @(negedge clk);
    bus.en_KCH = 1'b0;
    @(negedge clk);
    bus.HB_reset = 1'b1;
    bus.en_KCH = 1'b1;
    bus.fCH_ID = 16'd21;
    @(negedge clk);
    bus.HB_reset = 1'b0;
    bus.en_KCH = 1'b0;
    chk("hbScan.busy", bus.kch_busy, 0);
    chk("hbScan.drop", bus.kch_drop, 0);
    chkOut("hbScan", 16'h0, 16'hFFFF, 16'h0, 1'b0, 3'd0);
    @(negedge clk);
    chk("hbScan.idle", bus.kch_busy, 0);
    // nrst mid-SELECT
    advert(16'd25, 16'd3, 16'h2000, busyCyc, drops);
    chkOut("pre", 16'd25, 16'd3, 16'h2000, 1'b1, 3'd1);
    @(negedge clk);
    bus.en_KCH = 1'b1;
    {bus.fCH_ID, bus.fCH_Hops, bus.fCH_QValue} = {16'd26, 16'd1, 16'h3000};
    @(negedge clk);
    bus.en_KCH = 1'b0;
    repeat (6) @(negedge clk);
    chk("sel.busy", bus.kch_busy, 1);
    chkOut("sel.hold", 16'd25, 16'd3, 16'h2000, 1'b1, 3'd2);
    #1 nrst = 1'b0;
    #1;
    chk("nrst.busy", bus.kch_busy, 0);
    chkOut("nrst", 16'h0, 16'hFFFF, 16'h0, 1'b0, 3'd0);
    @(negedge clk);
    nrst = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
